dmem_responder: RTL

- Data-memory responder for the SEQ memory stage: the far end of the stage's load/store requests.
- Byte-addressable, MEM_BYTES deep. Serves 64-bit little-endian reads and writes.
- Fixed-latency request/response valid/ready handshake; one transaction in flight.
- Flags out-of-range accesses so the processor status logic can raise a memory-error status.

---
 rtl/dmem_responder_if.sv | 30 +++
 rtl/dmem_responder.sv | 116 +++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// Request/response bus between the memory stage (master) and the data
// memory responder (slave).
//   req_valid/req_ready  : request handshake, master -> slave
//   req_write            : 1 = store, 0 = load
//   req_addr             : byte address of the lowest byte
//   req_wdata            : store data, little-endian
//   resp_valid/resp_ready: response handshake, slave -> master
//   resp_rdata           : load data (0 for stores and errors)
//   resp_error           : access was out of range
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder for the SEQ memory stage. Byte-addressable store of
// MEM_BYTES bytes serving 64-bit little-endian loads and stores with a fixed
// LATENCY from request accept to response valid, one transaction in flight.
// Out-of-range accesses return resp_error=1 and leave memory untouched.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset (also reinitialises byte i to i mod 256)
//   bus  : dmem_responder_if slave modport (request/response handshakes)
module dmem_responder #(
    parameter int MEM_BYTES = 1024,
    parameter int LATENCY   = 2
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus
);
    localparam int AW = $clog2(MEM_BYTES);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt;
    logic            wr_q;
    logic [63:0]     addr_q;
    logic [63:0]     wdata_q;
    logic [63:0]     rdata_q;
    logic            error_q;
    logic [7:0]      mem [MEM_BYTES];

    logic [AW-1:0]   base;
    logic            access_err;
    logic [63:0]     load_word;

    // Full 64-bit compare so huge addresses cannot alias into range.
    assign access_err = addr_q > 64'(MEM_BYTES - 8);
    // Only meaningful when access_err is low, in which case base+7 fits in AW bits.
    assign base       = addr_q[AW-1:0];

    always_comb begin
        load_word = '0;
        for (int k = 0; k < 8; k++)
            load_word[8*k +: 8] = mem[base + AW'(k)];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next     = state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_next = BUSY;
            end
            BUSY: begin
                if (cnt == '0) state_next = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.resp_rdata = rdata_q;
    assign bus.resp_error = error_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
            for (int i = 0; i < MEM_BYTES; i++)
                mem[i] <= 8'(i);
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        wr_q    <= bus.req_write;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        cnt     <= CW'(LATENCY - 1);
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        error_q <= access_err;
                        rdata_q <= (!access_err && !wr_q) ? load_word : 64'd0;
                        if (!access_err && wr_q) begin
                            for (int k = 0; k < 8; k++)
                                mem[base + AW'(k)] <= wdata_q[8*k +: 8];
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        rdata_q <= '0;
                        error_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
